// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encoding, status bit positions and byte width.
package i2c_pkg;

  localparam int BYTE_W = 8;

  // Status byte layout; the master reuses STATUS_BUSY.
  localparam int STATUS_BUSY     = 7;
  localparam int STATUS_RX_VLD   = 6;
  localparam int STATUS_TX_DONE  = 5;
  localparam int STATUS_ADDR_HIT = 4;
  localparam int STATUS_RD_WR    = 3;
  localparam int STATUS_OVF      = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP,
    ST_IGNORE
  } slv_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for scl/sda with edge and START/STOP strobes.
module i2c_bus_sync (
  input  logic clk,
  input  logic rstn,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // Flops reset to 1 so an idle bus produces no edges after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, buffered write receive and read transmit.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter int         MAX_BYTES = 16,
  localparam int        BUF_W     = BYTE_W * MAX_BYTES,
  localparam int        CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             scl,
  inout  wire              sda,
  input  logic [BUF_W-1:0] slv_wfifo,
  output logic [BUF_W-1:0] slv_rfifo,
  output logic [CNT_W-1:0] slv_rx_cnt,
  output logic [7:0]       slv_status
);

  slv_state_e        state, state_nx;
  logic              sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic              fall_d;
  logic              sda_oe;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] tx_sr;
  logic [CNT_W-1:0]  rd_idx;
  logic              ack_ok;
  logic              m_nack;
  logic              addr_hit, rd_wr, ovf, rx_vld, tx_done;
  logic              rd_last;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign rd_last = (rd_idx == CNT_W'(MAX_BYTES - 1));

  // Byte idx of a buffer, byte 0 in the most significant position.
  function automatic logic [BYTE_W-1:0] byte_at(input logic [BUF_W-1:0] v,
                                                input logic [CNT_W-1:0] idx);
    logic [BUF_W-1:0] sh;
    sh = v << {idx, 3'b000};
    return sh[BUF_W-1 -: BYTE_W];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stop_det) begin
      state_nx = ST_IDLE;
    end else if (start_det) begin
      state_nx = ST_ADDR;
    end else if (scl_fall) begin
      case (state)
        ST_ADDR:     if (bit_cnt == 4'd8)
                       state_nx = (shreg[7:1] == SLV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: state_nx = rd_wr ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:  if (bit_cnt == 4'd8) state_nx = ST_WR_ACK;
        ST_WR_ACK:   state_nx = ST_WR_DATA;
        ST_RD_DATA:  if (bit_cnt == 4'd8) state_nx = ST_RD_ACK;
        ST_RD_ACK:   state_nx = (m_nack || rd_last) ? ST_WAIT_STOP : ST_RD_DATA;
        default:     state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fall_d     <= 1'b0;
      sda_oe     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_sr      <= '0;
      rd_idx     <= '0;
      ack_ok     <= 1'b0;
      m_nack     <= 1'b0;
      addr_hit   <= 1'b0;
      rd_wr      <= 1'b0;
      ovf        <= 1'b0;
      rx_vld     <= 1'b0;
      tx_done    <= 1'b0;
      slv_rfifo  <= '0;
      slv_rx_cnt <= '0;
    end else begin
      fall_d  <= scl_fall;
      rx_vld  <= 1'b0;
      tx_done <= 1'b0;
      if (stop_det) begin
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        if (state != ST_IDLE && addr_hit) begin
          rx_vld  <= ~rd_wr && (slv_rx_cnt != '0);
          tx_done <= rd_wr;
        end
      end else if (start_det) begin
        sda_oe   <= 1'b0;
        bit_cnt  <= '0;
        addr_hit <= 1'b0;
        rd_wr    <= 1'b0;
        ovf      <= 1'b0;
      end else begin
        if (scl_rise) begin
          case (state)
            ST_ADDR, ST_WR_DATA: begin
              shreg   <= {shreg[BYTE_W-2:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end
            ST_RD_DATA: begin
              tx_sr   <= {tx_sr[BYTE_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
            ST_RD_ACK: m_nack <= sda_s;
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            ST_ADDR: if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shreg[7:1] == SLV_ADDR) begin
                addr_hit <= 1'b1;
                rd_wr    <= shreg[0];
                rd_idx   <= '0;
                ack_ok   <= 1'b1;
              end
            end
            ST_ADDR_ACK: begin
              if (rd_wr) begin
                tx_sr <= byte_at(slv_wfifo, '0);
              end else begin
                slv_rfifo  <= '0;
                slv_rx_cnt <= '0;
              end
            end
            ST_WR_DATA: if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (slv_rx_cnt < CNT_W'(MAX_BYTES)) begin
                slv_rfifo  <= slv_rfifo | ({shreg, {(BUF_W-BYTE_W){1'b0}}} >> {slv_rx_cnt, 3'b000});
                slv_rx_cnt <= slv_rx_cnt + CNT_W'(1);
                ack_ok     <= 1'b1;
              end else begin
                ovf    <= 1'b1;
                ack_ok <= 1'b0;
              end
            end
            ST_RD_DATA: if (bit_cnt == 4'd8) bit_cnt <= '0;
            ST_RD_ACK: if (!(m_nack || rd_last)) begin
              rd_idx <= rd_idx + CNT_W'(1);
              tx_sr  <= byte_at(slv_wfifo, rd_idx + CNT_W'(1));
            end
            default: ;
          endcase
        end
        // Drive value for the bit that just began; held until the next scl fall.
        if (fall_d) begin
          case (state)
            ST_ADDR_ACK, ST_WR_ACK: sda_oe <= ack_ok;
            ST_RD_DATA:             sda_oe <= ~tx_sr[BYTE_W-1];
            default:                sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

  always_comb begin
    slv_status                  = '0;
    slv_status[STATUS_BUSY]     = (state != ST_IDLE);
    slv_status[STATUS_RX_VLD]   = rx_vld;
    slv_status[STATUS_TX_DONE]  = tx_done;
    slv_status[STATUS_ADDR_HIT] = addr_hit;
    slv_status[STATUS_RD_WR]    = rd_wr;
    slv_status[STATUS_OVF]      = ovf;
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bench-side bus master, pulse monitor, checked outputs.
module tb_i2c_slave;
  import i2c_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  logic         scl;
  logic         m_sda_oe;
  wire          sda;
  logic [127:0] slv_wfifo;
  logic [127:0] slv_rfifo;
  logic [4:0]   slv_rx_cnt;
  logic [7:0]   slv_status;

  int n_total     = 0;
  int n_bad       = 0;
  int rx_vld_cnt  = 0;
  int tx_done_cnt = 0;

  // Master side of the open-drain line; the pull-up supplies the released level.
  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLV_ADDR(7'h50), .MAX_BYTES(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .scl        (scl),
    .sda        (sda),
    .slv_wfifo  (slv_wfifo),
    .slv_rfifo  (slv_rfifo),
    .slv_rx_cnt (slv_rx_cnt),
    .slv_status (slv_status)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  // Counts cycles each strobe is high, so one clean pulse adds exactly 1.
  always @(negedge clk) begin
    if (slv_status[STATUS_RX_VLD])  rx_vld_cnt++;
    if (slv_status[STATUS_TX_DONE]) tx_done_cnt++;
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (all activity on negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; tick(4);
    scl = 1'b1;      tick(8);
    m_sda_oe = 1'b1; tick(8);
    scl = 1'b0;      tick(4);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; tick(4);
    scl = 1'b1;      tick(8);
    m_sda_oe = 1'b0; tick(8);
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b; tick(4);
    scl = 1'b1;    tick(8);
    scl = 1'b0;    tick(4);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_oe = 1'b0; tick(4);
    scl = 1'b1;      tick(4);
    b = sda;         tick(4);
    scl = 1'b0;      tick(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~give_ack);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] wr3 [3] = '{8'hA5, 8'h3C, 8'h0F};
  logic [7:0] c3_bits;

  initial begin
    logic       ack;
    logic       last_ack;
    logic [7:0] rb;
    int         acks;
    int         base_v;
    int         base_t;

    rstn      = 1'b0;
    scl       = 1'b1;
    m_sda_oe  = 1'b0;
    slv_wfifo = 128'h5A96_C3E1_0102_0304_0506_0708_090A_0B0C;
    tick(5);
    check("rst_status", slv_status, 8'h00);
    check("rst_rfifo", slv_rfifo, 128'h0);
    check("rst_rx_cnt", slv_rx_cnt, 5'd0);
    check("rst_sda", sda, 1'b1);
    rstn = 1'b1;
    tick(5);

    // Write three bytes to our address.
    base_v = rx_vld_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t1_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      write_byte(wr3[i], ack);
      check("t1_data_ack", ack, 1'b1);
    end
    check("t1_busy", slv_status[STATUS_BUSY], 1'b1);
    i2c_stop();
    tick(4);
    check("t1_rfifo", slv_rfifo, {24'hA53C0F, 104'h0});
    check("t1_rx_cnt", slv_rx_cnt, 5'd3);
    check("t1_rx_vld_pulse", rx_vld_cnt - base_v, 1);
    check("t1_status", slv_status, 8'h10);

    // Foreign address: no ACK, ignored until STOP.
    base_v = rx_vld_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    check("t2_addr_nack", ack, 1'b0);
    check("t2_state_ignore", dut.state, ST_IGNORE);
    write_byte(8'h55, ack);
    check("t2_data_nack", ack, 1'b0);
    i2c_stop();
    tick(4);
    check("t2_status", slv_status, 8'h00);
    check("t2_rfifo_kept", slv_rfifo, {24'hA53C0F, 104'h0});
    check("t2_state_idle", dut.state, ST_IDLE);
    check("t2_no_rx_vld", rx_vld_cnt - base_v, 0);

    // Read two bytes; second byte's source changes after it is loaded.
    base_t = tx_done_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check("t3_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b1);
    check("t3_byte0", rb, 8'h5A);
    slv_wfifo[119:112] = 8'hFF;
    read_byte(rb, 1'b0);
    check("t3_byte1", rb, 8'h96);
    slv_wfifo[119:112] = 8'h96;
    check("t3_sda_released", sda, 1'b1);
    check("t3_state_wait", dut.state, ST_WAIT_STOP);
    i2c_stop();
    tick(4);
    check("t3_tx_done_pulse", tx_done_cnt - base_t, 1);
    check("t3_status", slv_status, 8'h18);
    check("t3_rx_cnt_kept", slv_rx_cnt, 5'd3);

    // Seventeen bytes: last one overflows and is NACKed.
    base_v = rx_vld_cnt;
    acks   = 0;
    last_ack = 1'b1;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t4_addr_ack", ack, 1'b1);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'h11, ack);
      if (ack) acks++;
      last_ack = ack;
    end
    check("t4_ack_count", acks, 16);
    check("t4_last_nack", last_ack, 1'b0);
    check("t4_status_busy_ovf", slv_status, 8'h94);
    check("t4_rx_cnt", slv_rx_cnt, 5'd16);
    i2c_stop();
    tick(4);
    check("t4_rfifo", slv_rfifo, {16{8'h11}});
    check("t4_status", slv_status, 8'h14);
    check("t4_rx_vld_pulse", rx_vld_cnt - base_v, 1);

    // One write byte, repeated START, one read byte.
    base_v = rx_vld_cnt;
    base_t = tx_done_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t5_wr_addr_ack", ack, 1'b1);
    write_byte(8'h77, ack);
    check("t5_wr_ack", ack, 1'b1);
    i2c_start();
    write_byte(8'hA1, ack);
    check("t5_rd_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b0);
    check("t5_rd_byte", rb, 8'h5A);
    check("t5_status_busy", slv_status, 8'h98);
    i2c_stop();
    tick(4);
    check("t5_rx_cnt", slv_rx_cnt, 5'd1);
    check("t5_rfifo", slv_rfifo, {8'h77, 120'h0});
    check("t5_tx_done_pulse", tx_done_cnt - base_t, 1);
    check("t5_no_rx_vld", rx_vld_cnt - base_v, 0);
    check("t5_status", slv_status, 8'h18);

    // Reset in the middle of a write byte, then a clean write.
    c3_bits = 8'hC3;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t6_addr_ack", ack, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(c3_bits[i]);
    m_sda_oe = 1'b0;
    rstn     = 1'b0;
    tick(3);
    check("t6_rst_sda", sda, 1'b1);
    check("t6_rst_status", slv_status, 8'h00);
    check("t6_rst_rfifo", slv_rfifo, 128'h0);
    check("t6_rst_rx_cnt", slv_rx_cnt, 5'd0);
    scl = 1'b1;
    tick(4);
    rstn = 1'b1;
    tick(4);
    base_v = rx_vld_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t6_re_addr_ack", ack, 1'b1);
    write_byte(8'hC3, ack);
    check("t6_re_data_ack", ack, 1'b1);
    i2c_stop();
    tick(4);
    check("t6_rx_cnt", slv_rx_cnt, 5'd1);
    check("t6_rfifo", slv_rfifo, {8'hC3, 120'h0});
    check("t6_rx_vld_pulse", rx_vld_cnt - base_v, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
